// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one double-width working register, with valid/ready on both sides.
module muldiv_unit #(
    parameter int XLEN = 32,  // only 32 is supported
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int              CW       = $clog2(ITER);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_work;
    logic [XLEN-1:0]   r_opnd;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_fast;
    logic [1:0]        r_sel;
    logic [XLEN-1:0]   r_result;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_in_ready;

    // Operand decode for the operation being offered.
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_div_ovf, w_fast;
    logic [XLEN-1:0] w_fast_res;

    assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign w_a_neg    = w_a_signed & op_a[XLEN-1];
    assign w_b_neg    = w_b_signed & op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~op_a + 1'b1) : op_a;
    assign w_b_mag    = w_b_neg ? (~op_b + 1'b1) : op_b;
    assign w_div_zero = funct3[2] && (op_b == '0);
    assign w_div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    assign w_fast     = w_div_zero || w_div_ovf;
    assign w_fast_res = w_div_zero ? (funct3[1] ? op_a : '1)
                                   : (funct3[1] ? '0 : MIN_NEG);

    // One iteration step and the sign-corrected result of the final step.
    logic [XLEN:0]     w_mul_sum, w_div_rem, w_div_diff;
    logic [2*XLEN-1:0] w_step, w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_final;

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        w_mul_sum  = {1'b0, r_work[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_div_rem  = r_work[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_rem - {1'b0, r_opnd};
        w_step     = r_work;
        if (r_state == MUL) begin
            w_step = r_work[0] ? {w_mul_sum, r_work[XLEN-1:1]}
                               : {1'b0, r_work[2*XLEN-1:1]};
        end else if (!w_div_diff[XLEN]) begin
            w_step = {w_div_diff[XLEN-1:0], r_work[XLEN-2:0], 1'b1};
        end else begin
            w_step = {r_work[2*XLEN-2:0], 1'b0};
        end

        w_prod = r_neg_q ? (~w_step + 1'b1) : w_step;
        w_quo  = r_neg_q ? (~w_step[XLEN-1:0] + 1'b1) : w_step[XLEN-1:0];
        w_rem  = r_neg_r ? (~w_step[2*XLEN-1:XLEN] + 1'b1) : w_step[2*XLEN-1:XLEN];

        if (r_fast) begin
            w_final = r_work[XLEN-1:0];
        end else if (r_state == MUL) begin
            w_final = (r_sel == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            w_final = r_sel[1] ? w_rem : w_quo;
        end
    end

    // Fast-path operations park their answer in the working register and run a
    // single DIV step, so out_valid rises one cycle after accept.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_opnd      <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_fast      <= 1'b0;
            r_sel       <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sel      <= funct3[1:0];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_fast     <= w_fast;
                        r_busy     <= 1'b1;
                        r_in_ready <= 1'b0;
                        if (w_fast) begin
                            r_work  <= {{XLEN{1'b0}}, w_fast_res};
                            r_cnt   <= '0;
                            r_state <= DIV;
                        end else if (funct3[2]) begin
                            r_work  <= {{XLEN{1'b0}}, w_a_mag};
                            r_opnd  <= w_b_mag;
                            r_cnt   <= CNT_LOAD;
                            r_state <= DIV;
                        end else begin
                            r_work  <= {{XLEN{1'b0}}, w_b_mag};
                            r_opnd  <= w_a_mag;
                            r_cnt   <= CNT_LOAD;
                            r_state <= MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    r_work <= w_step;
                    if (r_cnt == '0) begin
                        r_result    <= w_final;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_busy;

endmodule
